// File: rtl/itrans_blk_sched_pkg.sv
// Shared definitions for the inverse-transform block scheduler: residual_state
// codes, descriptor layout, FSM states and the DC-before-AC gating rule.
package itrans_blk_sched_pkg;

   typedef enum logic [3:0] {
      RS_IDLE    = 4'd0,
      RS_LUMA4X4 = 4'd1,
      RS_I16_DC  = 4'd2,
      RS_I16_AC  = 4'd3,
      RS_CB_DC   = 4'd4,
      RS_CR_DC   = 4'd5,
      RS_CB_AC   = 4'd6,
      RS_CR_AC   = 4'd7
   } residual_state_e;

   localparam int unsigned DESC_W = 13;

   typedef struct packed {
      logic [3:0] state;
      logic [3:0] idx;
      logic [4:0] tc;
   } desc_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } sched_state_e;

   // AC blocks must wait for the DC block of the same component in this macroblock.
   function automatic logic dc_gate_blocked(input logic [3:0] st,
                                            input logic luma_done,
                                            input logic cb_done,
                                            input logic cr_done);
      return ((st == RS_I16_AC) && !luma_done) ||
             ((st == RS_CB_AC)  && !cb_done)   ||
             ((st == RS_CR_AC)  && !cr_done);
   endfunction

endpackage

// File: rtl/itrans_desc_fifo.sv
// Descriptor FIFO: DEPTH entries, ena-gated push/pop, full/empty/count.
module itrans_desc_fifo
   import itrans_blk_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = DESC_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Next-state: pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_push  = push && ena && !full;
      do_pop   = pop && ena && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/itrans_blk_sched.sv
// Inverse-transform block scheduler: queues residual-block descriptors, issues
// them one at a time to the transform controller with DC-before-AC ordering,
// and hands completed blocks to reconstruction over valid/ready.
module itrans_blk_sched
   import itrans_blk_sched_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 63,
   parameter int unsigned CW      = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       mb_start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_state,
   input  logic [3:0] in_blk_idx,
   input  logic [4:0] in_total_coeff,
   output logic       tf_start,
   output logic [3:0] tf_residual_state,
   output logic [4:0] tf_total_coeff,
   output logic [3:0] tf_luma_idx,
   output logic [1:0] tf_chroma_idx,
   input  logic       tf_valid,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_state,
   output logic [3:0] out_blk_idx,
   output logic       out_err,
   busy
);

   sched_state_e          state_q, state_d;
   logic [3:0]            st_q, st_d;
   logic [3:0]            idx_q, idx_d;
   logic [4:0]            tc_q, tc_d;
   logic                  err_q, err_d;
   logic [CW-1:0]         wd_q, wd_d;
   logic                  dc_luma_q, dc_luma_d;
   logic                  dc_cb_q, dc_cb_d;
   logic                  dc_cr_q, dc_cr_d;
   logic                  rdy_en_q, rdy_en_d;

   logic                  fifo_full, fifo_empty, fifo_pop;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [DESC_W-1:0]     fifo_dout;
   desc_t                 head;
   desc_t                 in_desc;

   assign in_desc = '{state: in_state, idx: in_blk_idx, tc: in_total_coeff};
   assign head    = desc_t'(fifo_dout);

   itrans_desc_fifo #(
      .DEPTH (DEPTH),
      .W     (DESC_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .push  (in_valid && in_ready),
      .din   (in_desc),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign in_ready          = rdy_en_q && !fifo_full;
   assign tf_start          = (state_q == S_ISSUE) && ena;
   assign out_valid         = (state_q == S_DONE);
   assign tf_residual_state = st_q;
   assign tf_total_coeff    = tc_q;
   assign tf_luma_idx       = idx_q;
   assign tf_chroma_idx     = idx_q[1:0];
   assign out_state         = st_q;
   assign out_blk_idx       = idx_q;
   assign out_err           = err_q;
   assign busy              = (state_q != S_IDLE) || (fifo_count != '0);

   // Next-state, issue/complete sequencing and DC-done flag maintenance.
   always_comb begin
      state_d   = state_q;
      st_d      = st_q;
      idx_d     = idx_q;
      tc_d      = tc_q;
      err_d     = err_q;
      wd_d      = wd_q;
      dc_luma_d = dc_luma_q;
      dc_cb_d   = dc_cb_q;
      dc_cr_d   = dc_cr_q;
      rdy_en_d  = 1'b1;
      fifo_pop  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty && !dc_gate_blocked(head.state, dc_luma_q, dc_cb_q, dc_cr_q)) begin
               state_d = S_ISSUE;
               st_d    = head.state;
               idx_d   = head.idx;
               tc_d    = head.tc;
               err_d   = 1'b0;
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // tf_valid is stale during the first WAIT cycle (wd_q == 0).
            if ((wd_q != '0) && tf_valid) begin
               state_d = S_DONE;
               err_d   = 1'b0;
            end else if (wd_q == CW'(TIMEOUT)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               fifo_pop = 1'b1;
               state_d  = S_IDLE;
               if (st_q == RS_I16_DC) dc_luma_d = 1'b1;
               if (st_q == RS_CB_DC)  dc_cb_d   = 1'b1;
               if (st_q == RS_CR_DC)  dc_cr_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (mb_start) begin
         dc_luma_d = 1'b0;
         dc_cb_d   = 1'b0;
         dc_cr_d   = 1'b0;
      end
   end

   // Scheduler registers; everything holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         st_q      <= '0;
         idx_q     <= '0;
         tc_q      <= '0;
         err_q     <= 1'b0;
         wd_q      <= '0;
         dc_luma_q <= 1'b0;
         dc_cb_q   <= 1'b0;
         dc_cr_q   <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else if (ena) begin
         state_q   <= state_d;
         st_q      <= st_d;
         idx_q     <= idx_d;
         tc_q      <= tc_d;
         err_q     <= err_d;
         wd_q      <= wd_d;
         dc_luma_q <= dc_luma_d;
         dc_cb_q   <= dc_cb_d;
         dc_cr_q   <= dc_cr_d;
         rdy_en_q  <= rdy_en_d;
      end
   end

endmodule
